// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life generation scheduler.
package gol_pkg;

  localparam int unsigned GOL_CLK_HZ = 32'd50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_STEP  = 2'd2,
    ST_LOAD  = 2'd3
  } gol_state_e;

endpackage

// File: rtl/gol_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a one-cycle edge detector.
module gol_sync_edge #(
  parameter bit RST_VAL   = 1'b0,
  parameter bit FALL_EDGE = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic async_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = FALL_EDGE ? (~sync_q & prev_q) : (sync_q & ~prev_q);

endmodule

// File: rtl/gol_gen_scheduler.sv
// Paces Game-of-Life generations: run-rate divider, single-step and clear requests,
// optionally aligned to VGA vertical blanking.
module gol_gen_scheduler
  import gol_pkg::*;
#(
  parameter int unsigned CLK_HZ      = GOL_CLK_HZ,
  parameter int unsigned GEN_W       = 16,
  parameter bit          SYNC_VBLANK = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             run,
  input  logic             step_req,
  input  logic             clear_req,
  input  logic [3:0]       speed,
  input  logic             vs,
  output logic             gen_en,
  output logic             load_en,
  output logic             busy,
  output logic             overrun,
  output logic [GEN_W-1:0] gen_count
);

  localparam int unsigned      CNT_W = $clog2(CLK_HZ + 1);
  localparam logic [CNT_W-1:0] BASE  = CNT_W'(CLK_HZ);

  logic             step_rise;
  logic             clr_rise;
  logic             vs_fall;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] term;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             arm_go;
  gol_state_e       state_q, state_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             overrun_q, overrun_d;

  gol_sync_edge #(.RST_VAL(1'b0), .FALL_EDGE(1'b0)) u_step_sync (
    .Clk(Clk), .Reset(Reset), .async_i(step_req), .edge_o(step_rise)
  );

  gol_sync_edge #(.RST_VAL(1'b0), .FALL_EDGE(1'b0)) u_clr_sync (
    .Clk(Clk), .Reset(Reset), .async_i(clear_req), .edge_o(clr_rise)
  );

  // vs idles high, so its flops reset high to avoid a false falling edge at release.
  gol_sync_edge #(.RST_VAL(1'b1), .FALL_EDGE(1'b1)) u_vs_sync (
    .Clk(Clk), .Reset(Reset), .async_i(vs), .edge_o(vs_fall)
  );

  // A period of 0 (large speed) degenerates to a tick every cycle; ">=" catches a
  // counter stranded above a freshly shortened terminal count.
  always_comb begin
    period = BASE >> speed;
    term   = (period == '0) ? '0 : period - CNT_W'(1);
    tick   = 1'b0;
    cnt_d  = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q >= term) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    gen_count_d = gen_count_q;
    overrun_d   = overrun_q;
    arm_go      = SYNC_VBLANK ? vs_fall : 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_rise) begin
          state_d = ST_LOAD;
        end else if ((run && tick) || (!run && step_rise)) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (clr_rise) begin
          state_d = ST_LOAD;
        end else begin
          if (run && tick) overrun_d = 1'b1;
          if (arm_go)      state_d   = ST_STEP;
        end
      end
      ST_STEP: begin
        gen_count_d = gen_count_q + GEN_W'(1);
        state_d     = clr_rise ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        gen_count_d = '0;
        overrun_d   = 1'b0;
        state_d     = clr_rise ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gen_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gen_count_q <= gen_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign gen_en    = (state_q == ST_STEP);
  assign load_en   = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Directed bench: instance A issues immediately, instance B waits for vertical sync.
module tb_gol_gen_scheduler;

  localparam int unsigned HZ = 1000;
  localparam int unsigned GW = 16;

  logic          Clk = 1'b0;
  logic          Reset, run, step_req, clear_req, vs;
  logic [3:0]    speed;
  logic          gen_en_a, load_en_a, busy_a, overrun_a;
  logic [GW-1:0] gen_count_a;
  logic          gen_en_b, load_en_b, busy_b, overrun_b;
  logic [GW-1:0] gen_count_b;

  int vectors = 0;
  int miscompares = 0;
  int np, nl, ng, ovl, first_load;
  int pos[8];

  always #5 Clk = ~Clk;

  gol_gen_scheduler #(.CLK_HZ(HZ), .GEN_W(GW), .SYNC_VBLANK(1'b0)) dut_a (
    .Clk(Clk), .Reset(Reset), .run(run), .step_req(step_req), .clear_req(clear_req),
    .speed(speed), .vs(vs), .gen_en(gen_en_a), .load_en(load_en_a), .busy(busy_a),
    .overrun(overrun_a), .gen_count(gen_count_a)
  );

  gol_gen_scheduler #(.CLK_HZ(HZ), .GEN_W(GW), .SYNC_VBLANK(1'b1)) dut_b (
    .Clk(Clk), .Reset(Reset), .run(run), .step_req(step_req), .clear_req(clear_req),
    .speed(speed), .vs(vs), .gen_en(gen_en_b), .load_en(load_en_b), .busy(busy_b),
    .overrun(overrun_b), .gen_count(gen_count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1; run = 1'b0; step_req = 1'b0; clear_req = 1'b0; speed = 4'd0; vs = 1'b1;
    cyc(2);
    Reset = 1'b0;
    cyc(1);
  endtask

  task automatic clr_pos();
    np = 0;
    for (int k = 0; k < 8; k++) pos[k] = 0;
  endtask

  task automatic step_vs();
    step_req = 1'b1; cyc(3); step_req = 1'b0; cyc(6);
    vs = 1'b0; cyc(3); vs = 1'b1; cyc(8);
  endtask

  initial begin
    Reset = 1'b1; run = 1'b0; step_req = 1'b0; clear_req = 1'b0; speed = 4'd0; vs = 1'b1;
    cyc(2);
    chk("rst_gen_en",    {31'd0, gen_en_a},  0);
    chk("rst_load_en",   {31'd0, load_en_a}, 0);
    chk("rst_busy",      {31'd0, busy_b},    0);
    chk("rst_overrun",   {31'd0, overrun_b}, 0);
    chk("rst_gen_count", {16'd0, gen_count_a}, 0);
    Reset = 1'b0;
    cyc(1);

    // Free-running at speed 2: period 250, plus one cycle in ARMED.
    run = 1'b1; speed = 4'd2; clr_pos(); ovl = 0;
    for (int i = 1; i <= 1005; i++) begin
      @(negedge Clk);
      if (gen_en_a) begin
        if (np < 8) pos[np] = i;
        np++;
      end
      if (gen_en_a && load_en_a) ovl++;
    end
    chk("run_pulses", np, 4);
    chk("run_p1", pos[0], 251);
    chk("run_p2", pos[1], 501);
    chk("run_p3", pos[2], 751);
    chk("run_p4", pos[3], 1001);
    chk("run_gen_count", {16'd0, gen_count_a}, 4);
    chk("run_overlap", ovl, 0);
    chk("run_overrun", {31'd0, overrun_a}, 0);

    // Paused single steps gated by vs falling every 100 cycles; the step at 40 is dropped.
    do_reset();
    clr_pos();
    for (int i = 1; i <= 400; i++) begin
      @(negedge Clk);
      if (gen_en_b) begin
        if (np < 8) pos[np] = i;
        np++;
      end
      if (i == 50) chk("step_armed_busy", {31'd0, busy_b}, 1);
      vs = ((i % 100) < 90);
      step_req = (i >= 10 && i < 13) || (i >= 40 && i < 43) ||
                 (i >= 110 && i < 113) || (i >= 210 && i < 213);
    end
    chk("step_pulses", np, 3);
    chk("step_p1", pos[0], 93);
    chk("step_p2", pos[1], 193);
    chk("step_p3", pos[2], 293);
    chk("step_gen_count", {16'd0, gen_count_b}, 3);

    // Asynchronous reset while ARMED.
    step_req = 1'b1; cyc(3); step_req = 1'b0; cyc(5);
    chk("ar_pre_busy", {31'd0, busy_b}, 1);
    chk("ar_pre_count", {16'd0, gen_count_b}, 3);
    #2 Reset = 1'b1;
    #1;
    chk("ar_busy",      {31'd0, busy_b},    0);
    chk("ar_gen_en",    {31'd0, gen_en_b},  0);
    chk("ar_load_en",   {31'd0, load_en_b}, 0);
    chk("ar_overrun",   {31'd0, overrun_b}, 0);
    chk("ar_gen_count", {16'd0, gen_count_b}, 0);
    @(negedge Clk);
    Reset = 1'b0;
    ng = 0; nl = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (gen_en_b) ng++;
      if (load_en_b) nl++;
      vs = !(i >= 5 && i < 8);
    end
    chk("ar_post_gen", ng, 0);
    chk("ar_post_load", nl, 0);

    // Five generations, arm a sixth, then clear.
    repeat (5) step_vs();
    chk("clr_pre_count", {16'd0, gen_count_b}, 5);
    step_req = 1'b1; cyc(3); step_req = 1'b0; cyc(5);
    chk("clr_pre_busy", {31'd0, busy_b}, 1);
    clear_req = 1'b1; ng = 0; nl = 0; first_load = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      if (load_en_b) begin
        if (nl == 0) first_load = i;
        nl++;
      end
      if (gen_en_b) ng++;
      if (i == 4) begin
        chk("clr_gen_count", {16'd0, gen_count_b}, 0);
        chk("clr_busy", {31'd0, busy_b}, 0);
      end
    end
    clear_req = 1'b0;
    chk("clr_loads", nl, 1);
    chk("clr_load_at", first_load, 3);
    chk("clr_gens", ng, 0);

    // Speed 8 gives a 3-cycle period; vs held high keeps B armed.
    do_reset();
    run = 1'b1; speed = 4'd8;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      if (i == 5) chk("ovr_before", {31'd0, overrun_b}, 0);
      if (i == 6) chk("ovr_after", {31'd0, overrun_b}, 1);
    end
    chk("ovr_gen_count", {16'd0, gen_count_b}, 0);
    chk("ovr_busy", {31'd0, busy_b}, 1);
    run = 1'b0; clear_req = 1'b1;
    cyc(6);
    chk("ovr_cleared", {31'd0, overrun_b}, 0);
    chk("ovr_idle", {31'd0, busy_b}, 0);
    clear_req = 1'b0;

    // Step edges are ignored while running.
    do_reset();
    run = 1'b1; speed = 4'd0;
    step_req = 1'b1; cyc(3); step_req = 1'b0;
    ng = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      if (busy_a || busy_b) ng++;
    end
    chk("runstep_busy", ng, 0);
    chk("runstep_count", {16'd0, gen_count_a}, 0);

    // Counter at 600 when speed drops the terminal count to 499.
    do_reset();
    run = 1'b1; speed = 4'd0; clr_pos();
    for (int i = 1; i <= 1105; i++) begin
      @(negedge Clk);
      if (gen_en_a) begin
        if (np < 8) pos[np] = i;
        np++;
      end
      if (i == 600) speed = 4'd1;
    end
    chk("spd_pulses", np, 2);
    chk("spd_first", pos[0], 602);
    chk("spd_restart", pos[1], 1102);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
